// File: rtl/div_issue.sv
// div_issue
// Initiator side of the divide-unit handshake. Takes one divide operation
// from the execute stage, strobes it into the divide unit once the unit is
// idle, waits for completion and presents the result on a valid/ready
// writeback port. Handles pipeline flushes of an in-flight divide and
// records divide-unit protocol violations and hangs in a sticky flag.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_clear               pipeline flush, abandons the current operation
//   i_op_valid/o_op_ready operation handshake from the execute stage
//   i_op_signed/num/den   operation operands, i_op_reg destination register
//   o_div_wr              one-cycle start strobe to the divide unit
//   o_div_signed/num/den  operands to the divide unit (held while pending)
//   i_div_busy/valid/err  divide-unit status, i_div_quotient/flags result
//   o_wb_valid/i_wb_ready writeback handshake to the register file
//   o_wb_reg/data/flags   captured destination, quotient and flags
//   o_wb_err              divide error or timeout
//   o_busy                an operation is in progress
//   o_proto_err           sticky divide-unit protocol violation
module div_issue #(
    parameter int BW      = 32,
    parameter int REGW    = 5,
    parameter int TIMEOUT = 40
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clear,
    input  logic            i_op_valid,
    output logic            o_op_ready,
    input  logic            i_op_signed,
    input  logic [BW-1:0]   i_op_num,
    input  logic [BW-1:0]   i_op_den,
    input  logic [REGW-1:0] i_op_reg,
    output logic            o_div_wr,
    output logic            o_div_signed,
    output logic [BW-1:0]   o_div_num,
    output logic [BW-1:0]   o_div_den,
    input  logic            i_div_busy,
    input  logic            i_div_valid,
    input  logic            i_div_err,
    input  logic [BW-1:0]   i_div_quotient,
    input  logic [3:0]      i_div_flags,
    output logic            o_wb_valid,
    input  logic            i_wb_ready,
    output logic [REGW-1:0] o_wb_reg,
    output logic [BW-1:0]   o_wb_data,
    output logic [3:0]      o_wb_flags,
    output logic            o_wb_err,
    output logic            o_busy,
    output logic            o_proto_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RESULT = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            div_busy_p1;
    logic            div_valid_p1;
    logic            accept;
    logic            timeout_hit;
    logic            proto_hit;

    assign accept = o_op_ready && i_op_valid;

    // Counter is zero on the first WAIT cycle, so TIMEOUT-1 marks the
    // TIMEOUT-th cycle spent waiting after the write strobe.
    assign timeout_hit = (wait_cnt >= CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (i_clear)
                    state_nxt = IDLE;
                else if (!i_div_busy)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (i_div_valid && i_clear)
                    state_nxt = IDLE;
                else if (i_div_valid)
                    state_nxt = RESULT;
                else if (i_clear)
                    state_nxt = DRAIN;
                else if (timeout_hit)
                    state_nxt = RESULT;
            end
            RESULT: if (i_clear || i_wb_ready) state_nxt = IDLE;
            DRAIN:  if (i_div_valid || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is applied
    always_comb begin
        o_op_ready = 1'b0;
        o_div_wr   = 1'b0;
        o_wb_valid = 1'b0;
        o_busy     = 1'b0;
        if (!i_reset) begin
            o_op_ready = (state == IDLE) && !i_clear;
            // A flush in the same cycle suppresses the strobe entirely.
            o_div_wr   = (state == ISSUE) && !i_div_busy && !i_clear;
            o_wb_valid = (state == RESULT);
            o_busy     = (state != IDLE);
        end
    end

    // Protocol checks on the divide-unit status lines
    always_comb begin
        proto_hit = 1'b0;
        if (i_div_busy && i_div_valid)
            proto_hit = 1'b1;
        if ((state == WAIT) && (wait_cnt == '0) && !i_div_busy)
            proto_hit = 1'b1;
        if (((state == WAIT) || (state == DRAIN)) && div_busy_p1 && !i_div_busy && !i_div_valid)
            proto_hit = 1'b1;
        if (div_valid_p1 && i_div_valid)
            proto_hit = 1'b1;
        if (i_div_valid && ((state == IDLE) || (state == ISSUE) || (state == RESULT)))
            proto_hit = 1'b1;
        if (i_div_err && !i_div_valid)
            proto_hit = 1'b1;
        if (((state == WAIT) && !i_div_valid && !i_clear && timeout_hit) ||
            ((state == DRAIN) && !i_div_valid && timeout_hit))
            proto_hit = 1'b1;
    end

    // Stage p1: previous-cycle divide-unit status and sticky error
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_busy_p1  <= 1'b0;
            div_valid_p1 <= 1'b0;
            o_proto_err  <= 1'b0;
        end else begin
            div_busy_p1  <= i_div_busy;
            div_valid_p1 <= i_div_valid;
            o_proto_err  <= o_proto_err | proto_hit;
        end
    end

    // Operand capture, wait counter and writeback result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_div_signed <= 1'b0;
            o_div_num    <= '0;
            o_div_den    <= '0;
            o_wb_reg     <= '0;
            o_wb_data    <= '0;
            o_wb_flags   <= '0;
            o_wb_err     <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            if (accept) begin
                o_div_signed <= i_op_signed;
                o_div_num    <= i_op_num;
                o_div_den    <= i_op_den;
                o_wb_reg     <= i_op_reg;
            end
            if (o_div_wr)
                wait_cnt <= '0;
            else if (((state == WAIT) || (state == DRAIN)) && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            if ((state == WAIT) && !i_clear) begin
                if (i_div_valid) begin
                    o_wb_data  <= i_div_quotient;
                    o_wb_flags <= i_div_flags;
                    o_wb_err   <= i_div_err;
                end else if (timeout_hit) begin
                    o_wb_data  <= '0;
                    o_wb_flags <= '0;
                    o_wb_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_issue.sv
module tb_div_issue;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_op_valid = 1'b0;
    logic        o_op_ready;
    logic        i_op_signed = 1'b0;
    logic [31:0] i_op_num = '0;
    logic [31:0] i_op_den = '0;
    logic [4:0]  i_op_reg = '0;
    logic        o_div_wr;
    logic        o_div_signed;
    logic [31:0] o_div_num;
    logic [31:0] o_div_den;
    logic        i_div_busy = 1'b0;
    logic        i_div_valid = 1'b0;
    logic        i_div_err = 1'b0;
    logic [31:0] i_div_quotient = '0;
    logic [3:0]  i_div_flags = '0;
    logic        o_wb_valid;
    logic        i_wb_ready = 1'b0;
    logic [4:0]  o_wb_reg;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_flags;
    logic        o_wb_err;
    logic        o_busy;
    logic        o_proto_err;

    int checks = 0;
    int errors = 0;

    div_issue #(.BW(32), .REGW(5), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
        .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
        .i_op_signed(i_op_signed), .i_op_num(i_op_num), .i_op_den(i_op_den),
        .i_op_reg(i_op_reg),
        .o_div_wr(o_div_wr), .o_div_signed(o_div_signed),
        .o_div_num(o_div_num), .o_div_den(o_div_den),
        .i_div_busy(i_div_busy), .i_div_valid(i_div_valid), .i_div_err(i_div_err),
        .i_div_quotient(i_div_quotient), .i_div_flags(i_div_flags),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_reg(o_wb_reg), .o_wb_data(o_wb_data), .o_wb_flags(o_wb_flags),
        .o_wb_err(o_wb_err), .o_busy(o_busy), .o_proto_err(o_proto_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic next_cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample;
        @(negedge i_clk);
    endtask

    // Presents one operation for a single cycle (DUT assumed idle).
    task automatic drive_op(input logic sgn, input logic [31:0] num,
                            input logic [31:0] den, input logic [4:0] rg);
        i_op_valid  = 1'b1;
        i_op_signed = sgn;
        i_op_num    = num;
        i_op_den    = den;
        i_op_reg    = rg;
    endtask

    task automatic test_reset;
        next_cyc;
        sample;
        checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_op_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto: got %b want 0", o_proto_err); end
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbvalid: got %b want 0", o_wb_valid); end
        next_cyc; i_reset = 1'b0;
        sample;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", o_op_ready); end
        checks++; if (o_div_wr !== 1'b0) begin errors++; $display("FAIL post_reset_wr: got %b want 0", o_div_wr); end
        checks++; if (o_wb_data !== 32'd0) begin errors++; $display("FAIL post_reset_data: got %0h want 0", o_wb_data); end
    endtask

    task automatic test_unsigned;
        int wr_cnt;
        next_cyc; drive_op(1'b0, 32'd100, 32'd7, 5'd3);
        sample;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL uns_ready: got %b want 1", o_op_ready); end
        next_cyc; i_op_valid = 1'b0;
        sample;
        wr_cnt = int'(o_div_wr);
        checks++; if (o_div_wr !== 1'b1) begin errors++; $display("FAIL uns_wr: got %b want 1", o_div_wr); end
        checks++; if (o_div_num !== 32'd100 || o_div_den !== 32'd7 || o_div_signed !== 1'b0)
            begin errors++; $display("FAIL uns_operands: got %0d/%0d s%b want 100/7 s0", o_div_num, o_div_den, o_div_signed); end
        for (int i = 0; i < 3; i++) begin
            next_cyc; i_div_busy = 1'b1;
            sample;
            wr_cnt += int'(o_div_wr);
            checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL uns_ready_busy: got %b want 0", o_op_ready); end
        end
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b1; i_div_quotient = 32'd14; i_div_flags = 4'h2;
        sample;
        wr_cnt += int'(o_div_wr);
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL uns_wb_early: got %b want 0", o_wb_valid); end
        next_cyc; i_div_valid = 1'b0; i_div_quotient = 32'hDEAD; i_div_flags = 4'hF; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_wb_valid !== 1'b1) begin errors++; $display("FAIL uns_wb_valid: got %b want 1", o_wb_valid); end
        checks++; if (o_wb_data !== 32'd14) begin errors++; $display("FAIL uns_wb_data: got %0d want 14", o_wb_data); end
        checks++; if (o_wb_reg !== 5'd3) begin errors++; $display("FAIL uns_wb_reg: got %0d want 3", o_wb_reg); end
        checks++; if (o_wb_flags !== 4'h2 || o_wb_err !== 1'b0)
            begin errors++; $display("FAIL uns_wb_flags_err: got %h/%b want 2/0", o_wb_flags, o_wb_err); end
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL uns_proto: got %b want 0", o_proto_err); end
        checks++; if (wr_cnt != 1) begin errors++; $display("FAIL uns_wr_count: got %0d want 1", wr_cnt); end
        next_cyc; i_wb_ready = 1'b0;
        sample;
        checks++; if (o_op_ready !== 1'b1 || o_wb_valid !== 1'b0)
            begin errors++; $display("FAIL uns_return_idle: got ready %b wbv %b want 1 0", o_op_ready, o_wb_valid); end
    endtask

    task automatic test_backpressure;
        next_cyc; drive_op(1'b0, 32'd100, 32'd7, 5'd3);
        next_cyc; i_op_valid = 1'b0;
        sample;
        checks++; if (o_div_wr !== 1'b1) begin errors++; $display("FAIL bp_wr: got %b want 1", o_div_wr); end
        for (int i = 0; i < 3; i++) begin next_cyc; i_div_busy = 1'b1; end
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b1; i_div_quotient = 32'd14; i_div_flags = 4'h2;
        for (int i = 0; i < 5; i++) begin
            next_cyc; i_div_valid = 1'b0; i_div_quotient = 32'h5555; i_div_flags = 4'h9;
            drive_op(1'b1, 32'd50, 32'd5, 5'd7);
            sample;
            checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd14 || o_wb_reg !== 5'd3 || o_wb_flags !== 4'h2)
                begin errors++; $display("FAIL bp_hold: got v%b d%0d r%0d f%h want v1 d14 r3 f2", o_wb_valid, o_wb_data, o_wb_reg, o_wb_flags); end
            checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b want 0", o_op_ready); end
        end
        next_cyc; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hs: got %b want 0", o_op_ready); end
        next_cyc; i_wb_ready = 1'b0;
        sample;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", o_op_ready); end
        next_cyc; i_op_valid = 1'b0;
        sample;
        checks++; if (o_div_wr !== 1'b1 || o_div_num !== 32'd50 || o_div_signed !== 1'b1)
            begin errors++; $display("FAIL bp_second_op: got wr%b num%0d s%b want wr1 num50 s1", o_div_wr, o_div_num, o_div_signed); end
        next_cyc; i_div_busy = 1'b1;
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b1; i_div_quotient = 32'd10; i_div_flags = 4'h0;
        next_cyc; i_div_valid = 1'b0; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd10 || o_wb_reg !== 5'd7)
            begin errors++; $display("FAIL bp_second_wb: got v%b d%0d r%0d want v1 d10 r7", o_wb_valid, o_wb_data, o_wb_reg); end
        next_cyc; i_wb_ready = 1'b0;
    endtask

    task automatic test_signed_div0;
        next_cyc; drive_op(1'b1, 32'hFFFF_FFF8, 32'd0, 5'd9);
        next_cyc; i_op_valid = 1'b0;
        sample;
        checks++; if (o_div_wr !== 1'b1 || o_div_signed !== 1'b1 || o_div_num !== 32'hFFFF_FFF8 || o_div_den !== 32'd0)
            begin errors++; $display("FAIL sdz_issue: got wr%b s%b num%h den%h want wr1 s1 fffffff8 0", o_div_wr, o_div_signed, o_div_num, o_div_den); end
        for (int i = 0; i < 2; i++) begin next_cyc; i_div_busy = 1'b1; end
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b1; i_div_err = 1'b1;
        i_div_quotient = 32'hFFFF_FFFF; i_div_flags = 4'h8;
        next_cyc; i_div_valid = 1'b0; i_div_err = 1'b0; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_wb_valid !== 1'b1 || o_wb_err !== 1'b1)
            begin errors++; $display("FAIL sdz_err: got v%b e%b want v1 e1", o_wb_valid, o_wb_err); end
        checks++; if (o_wb_data !== 32'hFFFF_FFFF || o_wb_flags !== 4'h8 || o_wb_reg !== 5'd9)
            begin errors++; $display("FAIL sdz_data: got d%h f%h r%0d want ffffffff 8 9", o_wb_data, o_wb_flags, o_wb_reg); end
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL sdz_proto: got %b want 0", o_proto_err); end
        next_cyc; i_wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        next_cyc; drive_op(1'b1, 32'd77, 32'd7, 5'd6);
        next_cyc; i_op_valid = 1'b0;
        next_cyc; i_div_busy = 1'b1;
        next_cyc; i_reset = 1'b1;
        next_cyc; i_reset = 1'b0; i_div_busy = 1'b0;
        sample;
        checks++; if (o_busy !== 1'b0 || o_div_wr !== 1'b0 || o_wb_valid !== 1'b0 || o_proto_err !== 1'b0)
            begin errors++; $display("FAIL rm_ctrl: got busy%b wr%b wbv%b pe%b want 0 0 0 0", o_busy, o_div_wr, o_wb_valid, o_proto_err); end
        checks++; if (o_div_signed !== 1'b0 || o_div_num !== 32'd0 || o_div_den !== 32'd0)
            begin errors++; $display("FAIL rm_div: got s%b num%0d den%0d want 0 0 0", o_div_signed, o_div_num, o_div_den); end
        checks++; if (o_wb_data !== 32'd0 || o_wb_reg !== 5'd0 || o_wb_flags !== 4'd0 || o_wb_err !== 1'b0)
            begin errors++; $display("FAIL rm_wb: got d%h r%0d f%h e%b want all 0", o_wb_data, o_wb_reg, o_wb_flags, o_wb_err); end
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", o_op_ready); end
        next_cyc; drive_op(1'b0, 32'd9, 32'd3, 5'd1);
        next_cyc; i_op_valid = 1'b0;
        next_cyc; i_div_busy = 1'b1;
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b1; i_div_quotient = 32'd3; i_div_flags = 4'h0;
        next_cyc; i_div_valid = 1'b0; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd3 || o_wb_reg !== 5'd1 || o_proto_err !== 1'b0)
            begin errors++; $display("FAIL rm_after: got v%b d%0d r%0d pe%b want v1 d3 r1 pe0", o_wb_valid, o_wb_data, o_wb_reg, o_proto_err); end
        next_cyc; i_wb_ready = 1'b0;
    endtask

    task automatic test_clear_drain;
        next_cyc; drive_op(1'b0, 32'd40, 32'd4, 5'd4);
        next_cyc; i_op_valid = 1'b0;
        next_cyc; i_div_busy = 1'b1;
        next_cyc; i_clear = 1'b1;
        sample;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL cd_busy: got %b want 1", o_busy); end
        next_cyc; i_clear = 1'b0;
        sample;
        checks++; if (o_wb_valid !== 1'b0 || o_op_ready !== 1'b0 || o_busy !== 1'b1)
            begin errors++; $display("FAIL cd_drain: got wbv%b rdy%b busy%b want 0 0 1", o_wb_valid, o_op_ready, o_busy); end
        next_cyc;
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b1; i_div_quotient = 32'd10;
        sample;
        checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL cd_ready_early: got %b want 0", o_op_ready); end
        next_cyc; i_div_valid = 1'b0;
        sample;
        checks++; if (o_op_ready !== 1'b1 || o_wb_valid !== 1'b0 || o_busy !== 1'b0)
            begin errors++; $display("FAIL cd_idle: got rdy%b wbv%b busy%b want 1 0 0", o_op_ready, o_wb_valid, o_busy); end
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL cd_proto: got %b want 0", o_proto_err); end
    endtask

    task automatic test_timeout;
        next_cyc; drive_op(1'b0, 32'd1, 32'd1, 5'd2);
        next_cyc; i_op_valid = 1'b0;
        sample;
        checks++; if (o_div_wr !== 1'b1) begin errors++; $display("FAIL to_wr: got %b want 1", o_div_wr); end
        for (int k = 1; k <= 8; k++) begin
            next_cyc; i_div_busy = 1'b1; i_div_quotient = 32'h1234; i_div_flags = 4'hF;
            sample;
            checks++; if (o_wb_valid !== 1'b0 || o_proto_err !== 1'b0)
                begin errors++; $display("FAIL to_early_%0d: got wbv%b pe%b want 0 0", k, o_wb_valid, o_proto_err); end
        end
        next_cyc; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd0 || o_wb_err !== 1'b1 || o_wb_flags !== 4'd0)
            begin errors++; $display("FAIL to_result: got v%b d%h e%b f%h want v1 d0 e1 f0", o_wb_valid, o_wb_data, o_wb_err, o_wb_flags); end
        checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL to_proto: got %b want 1", o_proto_err); end
        next_cyc; i_wb_ready = 1'b0; i_div_busy = 1'b0;
        sample;
        checks++; if (o_op_ready !== 1'b1 || o_proto_err !== 1'b1)
            begin errors++; $display("FAIL to_after: got rdy%b pe%b want 1 1", o_op_ready, o_proto_err); end
    endtask

    task automatic test_busy_valid;
        next_cyc; i_reset = 1'b1;
        next_cyc; i_reset = 1'b0;
        sample;
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL bv_cleared: got %b want 0", o_proto_err); end
        next_cyc; drive_op(1'b0, 32'd25, 32'd5, 5'd8);
        next_cyc; i_op_valid = 1'b0;
        next_cyc; i_div_busy = 1'b1;
        next_cyc; i_div_busy = 1'b1; i_div_valid = 1'b1; i_div_quotient = 32'd5;
        sample;
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL bv_before: got %b want 0", o_proto_err); end
        next_cyc; i_div_busy = 1'b0; i_div_valid = 1'b0; i_wb_ready = 1'b1;
        sample;
        checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL bv_set: got %b want 1", o_proto_err); end
        next_cyc; i_wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cyc;
            sample;
            checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL bv_sticky_%0d: got %b want 1", i, o_proto_err); end
        end
        next_cyc; i_reset = 1'b1;
        next_cyc; i_reset = 1'b0;
        sample;
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL bv_reset: got %b want 0", o_proto_err); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_backpressure;
        test_signed_div0;
        test_reset_mid;
        test_clear_drain;
        test_timeout;
        test_busy_valid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/div_issue.md
# div_issue

Initiator side of the CPU's divide-unit handshake. Accepts one divide operation at a time from the execute stage and pulses a single write into the divide unit. It waits for the divide unit's busy/valid completion, then holds the quotient, flags and error on a writeback valid/ready port until the register file takes them. It also handles pipeline flushes of an in-flight divide and flags any divide-unit protocol violation or timeout.

## Interface
- BW, 32, operand/quotient width
- REGW, 5, destination register index width
- TIMEOUT, 40, maximum cycles from o_div_wr to i_div_valid before declaring a hang (>=4)
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high; clock i_clk
- i_clear  in  1  pipeline flush: abandon current operation
- i_op_valid  in  1  execute stage presents a divide
- o_op_ready  out  1  operation accepted when i_op_valid && o_op_ready
- i_op_signed  in  1  signed divide request
- i_op_num, i_op_den  in  BW  numerator, denominator
- i_op_reg  in  REGW  destination register
- o_div_wr  out  1  single-cycle start strobe to divide unit
- o_div_signed  out  1  to divide unit
- o_div_num, o_div_den  out  BW  to divide unit; stable whenever o_div_wr=1
- i_div_busy, i_div_valid, i_div_err  in  1  divide unit status
- i_div_quotient  in  BW  divide result
- i_div_flags  in  4  divide result flags
- o_wb_valid  out  1  result pending writeback
- i_wb_ready  in  1  register file accepts result
- o_wb_reg  out  REGW  destination register
- o_wb_data  out  BW  quotient
- o_wb_flags  out  4  captured flags
- o_wb_err  out  1  divide error or timeout
- o_busy  out  1  state != IDLE
- o_proto_err  out  1  sticky divide-unit protocol violation, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, RESULT, DRAIN.
- IDLE:
  - o_op_ready = !i_clear.
  - On acceptance, latch signed/num/den/reg, then go to ISSUE.
- ISSUE:
  - o_div_wr = !i_div_busy. The divide unit must never see a write while busy.
  - When o_div_wr=1, go to WAIT and zero the wait counter.
  - If i_clear arrives before the write, go to IDLE and issue nothing.
- WAIT: the counter increments each cycle.
  - i_div_valid: capture quotient, flags and err, then go to RESULT.
  - i_clear without valid: go to DRAIN.
  - i_clear together with valid: discard the result, go to IDLE.
  - Counter reaches TIMEOUT: set o_proto_err, load o_wb_data=0, o_wb_err=1, o_wb_flags=0, go to RESULT.
- RESULT:
  - o_wb_valid=1; all o_wb_* held stable.
  - On i_wb_ready, go to IDLE.
  - On i_clear, drop the result and go to IDLE; clear wins over ready.
- DRAIN: wait for i_div_valid, discard it, go to IDLE. TIMEOUT applies here too: set o_proto_err and go to IDLE.
- o_proto_err is set on any of the following:
  - i_div_busy && i_div_valid in the same cycle.
  - i_div_busy low on the first WAIT cycle (the cycle after o_div_wr).
  - i_div_busy falling in WAIT/DRAIN without i_div_valid in that cycle.
  - i_div_valid high on two consecutive cycles.
  - i_div_valid in IDLE, ISSUE or RESULT (for example, late after a timeout).
  - i_div_err without i_div_valid.
- i_div_err with valid is a normal divide error (e.g. divide by zero). It sets o_wb_err and does not set o_proto_err.
- Flags and quotient pass through unmodified; no arithmetic is done in this block.

## Timing
- Reset value of every output is 0: state IDLE, o_div_* = 0, o_wb_* = 0, o_busy=0, o_proto_err=0. o_op_ready is 1 from the first cycle after reset.
- Sequence with acceptance at cycle T and a divider delay of N busy cycles:
  - o_div_wr at T+1 (later if i_div_busy).
  - i_div_busy from T+2 to T+1+N.
  - i_div_valid at T+2+N.
  - o_wb_valid at T+3+N.
- Throughput: one divide outstanding. The next acceptance happens at the earliest the cycle after the writeback handshake.
- o_div_wr is high for exactly one cycle per accepted, un-cleared operation.
- Reset mid-operation returns to IDLE immediately. Any divider result still arriving afterwards is ignored and does not set o_proto_err, because the divide unit is reset by the same signal.

## Test plan
- Unsigned divide, num=100, den=7, reg=3; divider model busy for 3 cycles then returns 14 -> exactly one o_div_wr; o_wb_valid with data=14, reg=3, err=0; o_proto_err=0.
- Same as above with i_wb_ready held low for 5 cycles -> o_wb_* stable for all 5 cycles; o_op_ready=0 throughout; a second op is accepted only after the handshake.
- Signed divide, num=-8, den=0; divider returns valid with err=1 -> o_wb_err=1; o_proto_err stays 0.
- i_clear on the second WAIT cycle -> state goes to DRAIN; no o_wb_valid; o_op_ready returns the cycle after the divider's valid.
- TIMEOUT=8, divider holds busy indefinitely -> o_proto_err=1 and o_wb_valid with data=0, err=1 at 9 cycles after o_div_wr. Separately, busy and valid asserted together -> o_proto_err=1 and sticky until i_reset.
- i_reset asserted in WAIT -> the next cycle all outputs are 0 and o_op_ready=1; a new op then completes normally.
